// File: rtl/ula_pkg.sv
// Shared definitions for the ULA operand-entry slice.
//   - estado_t and the entry FSM state codes (also shown on the board LEDs).
//   - ULA opcode constants, shared by the bench and the display logic.
package ula_pkg;

  typedef logic [1:0] estado_t;

  localparam estado_t ESPERA_A  = 2'b00;
  localparam estado_t ESPERA_B  = 2'b01;
  localparam estado_t ESPERA_OP = 2'b10;
  localparam estado_t PRONTO    = 2'b11;

  localparam logic [2:0] OP_SOMA = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MULT = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

endpackage

// File: rtl/debounce_botao.sv
// Conditions one raw push-button into a single-cycle press event.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn        : raw, bouncy, active-high button (asynchronous to clk)
//   pulso      : one clk cycle high when a debounced press is accepted
// The raw level is synchronized, must then hold a new level for
// DEBOUNCE_CYCLES consecutive cycles before it becomes the stable level,
// and the rising edge of the stable level produces the pulse.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulso
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CONT_FIM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   nivel_sync;
  logic [CW-1:0]          cont_q;
  logic                   estavel_q;
  logic                   estavel_d_q;

  assign nivel_sync = sync_q[SYNC_STAGES-1];

  // NOTE: the synchronizer chain is reset like any other flop so that no
  // phantom press can emerge from power-up garbage in the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // NOTE: sequential state is written with <= only, so every flop here
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_q      <= '0;
      estavel_q   <= 1'b0;
      estavel_d_q <= 1'b0;
    end else begin
      estavel_d_q <= estavel_q;
      if (nivel_sync == estavel_q) begin
        cont_q <= '0;
      end else if (cont_q == CONT_FIM) begin
        // Level held long enough: accept it; clearing here means no wrap.
        estavel_q <= nivel_sync;
        cont_q    <= '0;
      end else begin
        cont_q <= cont_q + CW'(1);
      end
    end
  end

  // Press only: the release edge of the stable level is ignored.
  assign pulso = estavel_q & ~estavel_d_q;

endmodule

// File: rtl/ula_entrada_operandos.sv
// Operand-entry stage for the 8-bit ULA.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   sw_dado[7:0] : data switches, captured into a then b on confirm
//   sw_op[2:0]   : operation switches, captured into sel_op on confirm
//   btn_confirma : raw confirm button (steps the entry FSM)
//   btn_cancela  : raw cancel button (returns to ESPERA_A, keeps operands)
//   a, b, sel_op : registered operands driving the ULA
//   valido       : registered, high while in PRONTO
//   estado       : current FSM state for the LEDs
module ula_entrada_operandos
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_dado,
  input  logic [2:0] sw_op,
  input  logic       btn_confirma,
  input  logic       btn_cancela,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [2:0] sel_op,
  output logic       valido,
  output logic [1:0] estado
);

  logic    pulso_conf;
  logic    pulso_canc;
  estado_t estado_q;
  estado_t estado_prox;
  logic    cap_a;
  logic    cap_b;
  logic    cap_op;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_deb_confirma (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_confirma),
    .pulso(pulso_conf)
  );

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_deb_cancela (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_cancela),
    .pulso(pulso_canc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= ESPERA_A;
    end else begin
      estado_q <= estado_prox;
    end
  end

  // NOTE: a default assignment first keeps this block purely combinational;
  // without it an unassigned path would infer a latch.
  always_comb begin
    estado_prox = estado_q;
    if (pulso_canc) begin
      estado_prox = ESPERA_A;           // cancel wins over a same-cycle confirm
    end else if (pulso_conf) begin
      case (estado_q)
        ESPERA_A:  estado_prox = ESPERA_B;
        ESPERA_B:  estado_prox = ESPERA_OP;
        ESPERA_OP: estado_prox = PRONTO;
        default:   estado_prox = ESPERA_A;
      endcase
    end
  end

  // Capture strobes coincide with the transition out of the capturing state.
  always_comb begin
    cap_a  = 1'b0;
    cap_b  = 1'b0;
    cap_op = 1'b0;
    if (pulso_conf && !pulso_canc) begin
      case (estado_q)
        ESPERA_A:  cap_a  = 1'b1;
        ESPERA_B:  cap_b  = 1'b1;
        ESPERA_OP: cap_op = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      sel_op <= '0;
      valido <= 1'b0;
    end else begin
      if (cap_a)  a      <= sw_dado;
      if (cap_b)  b      <= sw_dado;
      if (cap_op) sel_op <= sw_op;
      valido <= (estado_prox == PRONTO);
    end
  end

  assign estado = estado_q;

endmodule

// File: tb/tb_ula_entrada_operandos.sv
module tb_ula_entrada_operandos;
  import ula_pkg::*;

  localparam int D    = 4;
  localparam int S    = 2;
  localparam int HOLD = D + S + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw_dado = '0;
  logic [2:0] sw_op = '0;
  logic       btn_confirma = 1'b0;
  logic       btn_cancela = 1'b0;
  logic [7:0] a, b;
  logic [2:0] sel_op;
  logic       valido;
  logic [1:0] estado;

  int n_checks = 0;
  int n_pass   = 0;

  ula_entrada_operandos #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .sw_dado(sw_dado), .sw_op(sw_op),
    .btn_confirma(btn_confirma), .btn_cancela(btn_cancela),
    .a(a), .b(b), .sel_op(sel_op), .valido(valido), .estado(estado)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // A button level counts once it has been seen (S cycles late) with the
  // same new value on D consecutive edges; a press event acts on the FSM
  // one edge after the level is accepted.
  logic [7:0] m_a, m_b;
  logic [2:0] m_op;
  logic       m_val;
  logic [1:0] m_est;
  bit         hist [2][S];
  bit         m_stab [2];
  bit         m_last [2];
  int         m_run [2];
  bit         m_p [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_op = '0; m_val = 1'b0; m_est = ESPERA_A;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < S; k++) hist[i][k] = 1'b0;
        m_stab[i] = 1'b0; m_last[i] = 1'b0; m_run[i] = 0; m_p[i] = 1'b0;
      end
    end else begin
      if (m_p[1]) begin
        m_est = ESPERA_A;
      end else if (m_p[0]) begin
        if (m_est == ESPERA_A) begin m_a = sw_dado; m_est = ESPERA_B; end
        else if (m_est == ESPERA_B) begin m_b = sw_dado; m_est = ESPERA_OP; end
        else if (m_est == ESPERA_OP) begin m_op = sw_op; m_est = PRONTO; end
        else m_est = ESPERA_A;
      end
      m_val = (m_est == PRONTO);
      for (int i = 0; i < 2; i++) begin
        bit raw, seen;
        raw  = (i == 0) ? btn_confirma : btn_cancela;
        seen = hist[i][S-1];
        for (int k = S - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = raw;
        if (seen == m_last[i]) m_run[i]++; else m_run[i] = 1;
        m_last[i] = seen;
        m_p[i] = 1'b0;
        if (seen != m_stab[i] && m_run[i] >= D) begin
          m_stab[i] = seen;
          m_p[i]    = seen;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    btn_confirma = 1'b0;
    btn_cancela  = 1'b0;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic tap(input bit conf, input bit canc);
    btn_confirma = conf;
    btn_cancela  = canc;
    idle(HOLD);
    btn_confirma = 1'b0;
    btn_cancela  = 1'b0;
    idle(HOLD);
  endtask

  // Called right after a raw edge was driven; the next edge samples it.
  // Returns the number of further edges until estado changes.
  task automatic measure_edges(output int n, output bit ok);
    logic [1:0] old;
    old = estado;
    ok  = 1'b0;
    n   = 0;
    @(posedge clk);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (estado !== old) ok = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #3;
    n_checks++;
    if ({a, b, sel_op, valido, estado} !== 22'd0)
      $display("FAIL reset_state: got %h required 0", {a, b, sel_op, valido, estado});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_full_entry();
    int n; bit ok;
    do_reset();
    for (int step = 0; step < 3; step++) begin
      if (step == 0) sw_dado = 8'h2A;
      else if (step == 1) sw_dado = 8'h05;
      else sw_op = OP_SUB;
      btn_confirma = 1'b1;
      measure_edges(n, ok);
      n_checks++;
      if (!ok || n != S + D)
        $display("FAIL entry_latency step %0d: got %0d edges (seen=%0b) required %0d", step, n, ok, S + D);
      else n_pass++;
      idle(HOLD);
      btn_confirma = 1'b0;
      sw_dado = 8'h77;
      idle(HOLD);
    end
    n_checks++;
    if ({a, b, sel_op, valido, estado} !== {8'h2A, 8'h05, OP_SUB, 1'b1, PRONTO})
      $display("FAIL entry_result: got a=%h b=%h op=%0d v=%b est=%b required a=2a b=05 op=1 v=1 est=11",
               a, b, sel_op, valido, estado);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int n, d, total, extra; bit ok; bit lvl; logic [7:0] v; logic [1:0] prev;
    do_reset();
    v = 8'($urandom);
    sw_dado = v;
    lvl = 1'b0; total = 0;
    while (total < 20) begin
      lvl = ~lvl;
      btn_confirma = lvl;
      d = $urandom_range(1, 3);
      idle(d);
      total += d;
    end
    if (lvl) begin
      btn_confirma = 1'b0;
      idle($urandom_range(1, 3));
    end
    btn_confirma = 1'b1;
    measure_edges(n, ok);
    n_checks++;
    if (!ok || n != S + D)
      $display("FAIL bounce_latency: got %0d edges (seen=%0b) required %0d", n, ok, S + D);
    else n_pass++;
    extra = 0; prev = estado;
    repeat (40) begin
      @(negedge clk);
      if (estado !== prev) begin extra++; prev = estado; end
    end
    n_checks++;
    if (extra != 0 || estado !== ESPERA_B || a !== v)
      $display("FAIL bounce_single: got extra=%0d est=%b a=%h required extra=0 est=01 a=%h",
               extra, estado, a, v);
    else n_pass++;
    @(posedge clk); #1;
    btn_confirma = 1'b0;
    idle(HOLD);
  endtask

  task automatic test_held();
    int chg; logic [1:0] prev; logic [7:0] vb;
    do_reset();
    sw_dado = 8'($urandom);
    btn_confirma = 1'b1;
    chg = 0; prev = estado;
    repeat (100) begin
      @(negedge clk);
      if (estado !== prev) begin chg++; prev = estado; end
    end
    n_checks++;
    if (chg != 1 || estado !== ESPERA_B)
      $display("FAIL held_single: got changes=%0d est=%b required changes=1 est=01", chg, estado);
    else n_pass++;
    btn_confirma = 1'b0;
    idle(20);
    n_checks++;
    if (estado !== ESPERA_B)
      $display("FAIL held_release: got est=%b required 01", estado);
    else n_pass++;
    vb = 8'($urandom);
    sw_dado = vb;
    tap(1'b1, 1'b0);
    n_checks++;
    if (estado !== ESPERA_OP || b !== vb)
      $display("FAIL held_repress: got est=%b b=%h required est=10 b=%h", estado, b, vb);
    else n_pass++;
  endtask

  task automatic test_cancel();
    do_reset();
    sw_dado = 8'h10; tap(1'b1, 1'b0);
    sw_dado = 8'h20; tap(1'b1, 1'b0);
    n_checks++;
    if (estado !== ESPERA_OP)
      $display("FAIL cancel_setup: got est=%b required 10", estado);
    else n_pass++;
    sw_dado = 8'h99;
    tap(1'b0, 1'b1);
    n_checks++;
    if ({estado, valido, a, b} !== {ESPERA_A, 1'b0, 8'h10, 8'h20})
      $display("FAIL cancel_op: got est=%b v=%b a=%h b=%h required est=00 v=0 a=10 b=20",
               estado, valido, a, b);
    else n_pass++;
    sw_dado = 8'h10; tap(1'b1, 1'b0);
    sw_dado = 8'h20; tap(1'b1, 1'b0);
    sw_op = OP_OR;   tap(1'b1, 1'b0);
    n_checks++;
    if (valido !== 1'b1 || estado !== PRONTO)
      $display("FAIL cancel_pronto_setup: got est=%b v=%b required est=11 v=1", estado, valido);
    else n_pass++;
    sw_op = OP_NOT;
    tap(1'b0, 1'b1);
    n_checks++;
    if ({estado, valido, a, b, sel_op} !== {ESPERA_A, 1'b0, 8'h10, 8'h20, OP_OR})
      $display("FAIL cancel_pronto: got est=%b v=%b a=%h b=%h op=%0d required est=00 v=0 a=10 b=20 op=5",
               estado, valido, a, b, sel_op);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] va;
    do_reset();
    va = 8'($urandom);
    sw_dado = va;
    tap(1'b1, 1'b0);
    sw_dado = 8'($urandom) | 8'h01;
    tap(1'b1, 1'b1);
    n_checks++;
    if ({estado, a, b} !== {ESPERA_A, va, 8'h00})
      $display("FAIL simultaneous: got est=%b a=%h b=%h required est=00 a=%h b=00", estado, a, b, va);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    sw_dado = 8'hFF;         tap(1'b1, 1'b0);
    sw_dado = 8'($urandom);  tap(1'b1, 1'b0);
    sw_op = 3'($urandom);    tap(1'b1, 1'b0);
    n_checks++;
    if (a !== 8'hFF || estado !== PRONTO || valido !== 1'b1)
      $display("FAIL async_setup: got a=%h est=%b v=%b required a=ff est=11 v=1", a, estado, valido);
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a, b, sel_op, valido, estado} !== 22'd0)
      $display("FAIL async_reset: got %h required 0 before next edge", {a, b, sel_op, valido, estado});
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sw_dado = 8'h5A;
    idle(20);
    n_checks++;
    if (a !== 8'h00 || estado !== ESPERA_A)
      $display("FAIL async_no_press: got a=%h est=%b required a=00 est=00", a, estado);
    else n_pass++;
  endtask

  task automatic test_random();
    int d;
    do_reset();
    repeat (40) begin
      sw_dado      = 8'($urandom);
      sw_op        = 3'($urandom);
      btn_confirma = 1'($urandom_range(0, 1));
      btn_cancela  = ($urandom_range(0, 5) == 0);
      d = $urandom_range(1, 12);
      repeat (d) begin
        @(negedge clk);
        n_checks++;
        if ({a, b, sel_op, valido, estado} !== {m_a, m_b, m_op, m_val, m_est})
          $display("FAIL random_model: got a=%h b=%h op=%0d v=%b est=%b required a=%h b=%h op=%0d v=%b est=%b",
                   a, b, sel_op, valido, estado, m_a, m_b, m_op, m_val, m_est);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    btn_confirma = 1'b0;
    btn_cancela  = 1'b0;
    idle(HOLD);
  endtask

  initial begin
    test_reset();
    test_full_entry();
    test_bounce();
    test_held();
    test_cancel();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ula_entrada_operandos.md
Name: ula_entrada_operandos

Overview:
- Upstream operand-entry stage for the 8-bit ULA on the FPGA board.
- Turns the 8 data switches, the 3 op switches and two raw push-buttons into stable registered operands `a`, `b` and `sel_op`, which drive the ULA directly.
- A confirm button steps through a 4-state entry FSM, capturing A, then B, then the operation, and then flags the operands valid.
- A cancel button aborts the entry at any time.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles a synchronized button level must hold before it is accepted (10 ms at 50 MHz). Legal range ≥ 2.
- SYNC_STAGES, 2, number of flip-flops in each button synchronizer. Legal range ≥ 2.

Ports:
- clk  input  1  system clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- sw_dado  input  8  data switches; asynchronous to clk, sampled only at a capture event.
- sw_op  input  3  operation switches; asynchronous to clk, sampled only at a capture event.
- btn_confirma  input  1  raw confirm button, active-high, bouncy.
- btn_cancela  input  1  raw cancel button, active-high, bouncy.
- a  output  8  registered operand A to the ULA.
- b  output  8  registered operand B to the ULA.
- sel_op  output  3  registered operation select to the ULA.
- valido  output  1  high while the FSM is in PRONTO.
- estado  output  2  current FSM state encoding, for the board LEDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - a = 0, b = 0, sel_op = 0, valido = 0.
  - FSM returns to ESPERA_A; estado = 2'b00.
  - All synchronizer flops, debounce counters and stable levels clear to 0.
  - Reset mid-entry discards any partially captured values.
- Button conditioning, per button:
  - The raw input passes through a SYNC_STAGES flop chain.
  - Debounce counter: cleared to 0 whenever the synchronized level equals the stable level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ: stable takes the synchronized level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
  - Event pulse = stable & ~stable_delayed: exactly 1 cycle wide, generated on the press only, never on release.
  - Latency from a clean raw edge to the pulse: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- FSM states, with estado encoding:
  - ESPERA_A (00): on confirm, a <= sw_dado, then go to ESPERA_B.
  - ESPERA_B (01): on confirm, b <= sw_dado, then go to ESPERA_OP.
  - ESPERA_OP (10): on confirm, sel_op <= sw_op, then go to PRONTO.
  - PRONTO (11): on confirm, go to ESPERA_A without modifying a, b or sel_op.
- Every capture happens on the same clk edge as the state transition.
- valido is registered: it rises on the edge that enters PRONTO and falls on the edge that leaves it.
- Cancel pulse in any state: go to ESPERA_A on the next edge. a, b and sel_op hold their values; valido falls.
- Cancel and confirm pulse in the same cycle: cancel wins and no capture occurs.
- Between capture events, a, b and sel_op hold their values regardless of switch activity. Switches are not synchronized: they are treated as quasi-static during a button press.
- Holding a button down produces one event only. A new event requires a release that is accepted by the debouncer, then a new press.
- Counter width is $clog2(DEBOUNCE_CYCLES). There is no wrap-around, because the counter clears at its terminal count.

Decomposition:
- Shared package (ula_pkg):
  - FSM state localparams: ESPERA_A = 2'b00, ESPERA_B = 2'b01, ESPERA_OP = 2'b10, PRONTO = 2'b11.
  - ULA opcode constants: 0 SOMA, 1 SUB, 2 MULT, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, for reuse by the bench and the display logic.
- Sub-module: debounce_botao. It contains the synchronizer, the debounce counter and the edge pulse, takes the same two parameters, and is instantiated twice (confirm, cancel).
- The FSM and the operand registers stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset, then a full entry:
   - Stimulus: sw_dado=8'h2A, press confirm; sw_dado=8'h05, press confirm; sw_op=3'd1, press confirm.
   - Required: a=8'h2A, b=8'h05, sel_op=1, valido=1, estado=11; each capture lands exactly 6 cycles after its raw press edge.
2. Bounce rejection:
   - Stimulus: confirm toggles with 1-3 cycle pulses for 20 cycles, then holds high.
   - Required: exactly one capture, occurring 4 cycles after the last toggle plus the synchronizer delay.
3. Button held:
   - Stimulus: confirm held high for 100 cycles in ESPERA_A.
   - Required: a single transition to ESPERA_B, with no further advance until release and re-press.
4. Cancel:
   - Stimulus: in ESPERA_OP with a=8'h10 and b=8'h20, press cancel.
   - Required: estado=00, valido=0, a=8'h10, b=8'h20 unchanged.
5. Simultaneous events:
   - Stimulus: confirm and cancel pressed on the same cycle while in ESPERA_B.
   - Required: estado=00, b unchanged.
6. Asynchronous reset:
   - Stimulus: assert rst_n low mid-cycle while in PRONTO with a=8'hFF.
   - Required: outputs clear to 0 and estado=00 immediately, without waiting for a clock edge.
   - Then a switch change with no press leaves a = 0.
